// File: rtl/mainfsm_mc.sv
// Multicycle main control FSM for the ARM multicycle datapath.
// Adds memory wait states, a multi-cycle FPU execute phase, an optional
// FP16 path, an illegal-instruction flag and a visible state encoding.
module mainfsm_mc #(
   parameter int FPU_LAT  = 3,     // extra execute cycles for FP ops, 0..15
   parameter bit EN_FPU16 = 1'b1   // 0 turns FP16 commands into UNKNOWN
) (
   input  logic       clk,
   input  logic       reset,       // asynchronous, active low
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic       MemReady,
   output logic       IRWrite,
   output logic       AdrSrc,
   output logic       NextPC,
   output logic       RegW,
   output logic       RegW2,
   output logic       MemW,
   output logic       Branch,
   output logic       ALUOp,
   output logic       Half,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic       FpuStart,
   output logic       Illegal,
   output logic [3:0] State
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,  DECODE   = 4'd1,  MEMADR   = 4'd2,  MEMRD    = 4'd3,
      MEMWB    = 4'd4,  MEMWRITE = 4'd5,  EXECUTER = 4'd6,  EXECUTEI = 4'd7,
      ALUWB    = 4'd8,  BRANCH   = 4'd9,  UNKNOWN  = 4'd10, ALUWB2   = 4'd11,
      FPUWB    = 4'd12, FPU16WB  = 4'd13, FPUEXEC  = 4'd14
   } state_t;

   // FPUEXEC runs FPU_LAT cycles: counter loads FPU_LAT-1 and exits at 0.
   localparam bit         HAS_LAT  = (FPU_LAT > 0);
   localparam logic [3:0] LAT_INIT = HAS_LAT ? 4'(FPU_LAT - 1) : 4'd0;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       fp16_q, fp16_d;     // FP16 op in flight, selects the WB state
   logic       imm_q, imm_d;       // immediate operand, keeps ALUSrcB in FPUEXEC

   logic [3:0] cmd;
   logic       is_long, is_fp32, is_fp16, fp16_ok, bad16, is_fp;

   // Command classification from Funct[4:1]
   always_comb begin
      cmd     = Funct[4:1];
      is_long = (cmd == 4'b1001) || (cmd == 4'b1010);
      is_fp32 = (cmd[3:1] == 3'b111);
      is_fp16 = (cmd[3:1] == 3'b011);
      fp16_ok = is_fp16 & EN_FPU16;
      bad16   = is_fp16 & ~EN_FPU16;
      is_fp   = is_fp32 | fp16_ok;
   end

   // State, FPU counter and execute-phase latches
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= FETCH;
         cnt_q   <= 4'd0;
         fp16_q  <= 1'b0;
         imm_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fp16_q  <= fp16_d;
         imm_q   <= imm_d;
      end
   end

   // Next-state and datapath control decode
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      fp16_d    = fp16_q;
      imm_d     = imm_q;
      IRWrite   = 1'b0;
      AdrSrc    = 1'b0;
      NextPC    = 1'b0;
      RegW      = 1'b0;
      RegW2     = 1'b0;
      MemW      = 1'b0;
      Branch    = 1'b0;
      ALUOp     = 1'b0;
      Half      = 1'b0;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ResultSrc = 2'b00;
      FpuStart  = 1'b0;
      Illegal   = 1'b0;
      case (state_q)
         FETCH: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            IRWrite   = MemReady;
            NextPC    = MemReady;
            if (MemReady) state_d = DECODE;
         end
         DECODE: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            case (Op)
               2'b00:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
               2'b01:   state_d = MEMADR;
               2'b10:   state_d = BRANCH;
               default: state_d = UNKNOWN;
            endcase
         end
         EXECUTER, EXECUTEI: begin
            ALUOp    = 1'b1;
            if (state_q == EXECUTEI) ALUSrcB = 2'b01;
            FpuStart = is_fp;
            fp16_d   = fp16_ok;
            imm_d    = Funct[5];
            if (is_long)    state_d = ALUWB2;
            else if (bad16) state_d = UNKNOWN;
            else if (is_fp) begin
               if (HAS_LAT) begin
                  state_d = FPUEXEC;
                  cnt_d   = LAT_INIT;
               end else begin
                  state_d = fp16_ok ? FPU16WB : FPUWB;
               end
            end else        state_d = ALUWB;
         end
         FPUEXEC: begin
            ALUOp   = 1'b1;
            ALUSrcB = imm_q ? 2'b01 : 2'b00;
            if (cnt_q == 4'd0) state_d = fp16_q ? FPU16WB : FPUWB;
            else               cnt_d   = cnt_q - 4'd1;
         end
         MEMADR: begin
            ALUSrcB = 2'b01;
            state_d = Funct[0] ? MEMRD : MEMWRITE;
         end
         MEMRD: begin
            AdrSrc = 1'b1;
            if (MemReady) state_d = MEMWB;
         end
         MEMWB: begin
            RegW      = 1'b1;
            ResultSrc = 2'b01;
            state_d   = FETCH;
         end
         MEMWRITE: begin
            AdrSrc = 1'b1;
            MemW   = 1'b1;
            if (MemReady) state_d = FETCH;
         end
         ALUWB: begin
            RegW    = 1'b1;
            state_d = FETCH;
         end
         ALUWB2: begin
            RegW    = 1'b1;
            RegW2   = 1'b1;
            state_d = FETCH;
         end
         FPUWB: begin
            RegW      = 1'b1;
            ResultSrc = 2'b11;
            state_d   = FETCH;
         end
         FPU16WB: begin
            RegW      = 1'b1;
            ResultSrc = 2'b11;
            Half      = 1'b1;
            state_d   = FETCH;
         end
         BRANCH: begin
            Branch    = 1'b1;
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            state_d   = FETCH;
         end
         UNKNOWN: begin
            Illegal = 1'b1;
            state_d = FETCH;
         end
         default: state_d = FETCH;
      endcase
   end

   assign State = state_q;

endmodule

// File: tb/tb_mainfsm_mc.sv
// Scoreboard bench: two controllers (FP16 enabled / disabled, FPU_LAT=3)
// share stimulus; each cycle's expected control words are queued by the
// stimulus and checked by an independent monitor on the falling edge.
module tb_mainfsm_mc;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] op = 2'b00;
   logic [5:0] funct = 6'b0;
   logic       mem_ready = 1'b0;

   logic       a_irw, a_adr, a_npc, a_rw, a_rw2, a_mw, a_br, a_aop, a_half, a_fs, a_ill;
   logic [1:0] a_sa, a_sb, a_res;
   logic [3:0] a_st;
   logic       b_irw, b_adr, b_npc, b_rw, b_rw2, b_mw, b_br, b_aop, b_half, b_fs, b_ill;
   logic [1:0] b_sa, b_sb, b_res;
   logic [3:0] b_st;

   mainfsm_mc #(.FPU_LAT(3), .EN_FPU16(1'b1)) dut_a (
      .clk(clk), .reset(reset), .Op(op), .Funct(funct), .MemReady(mem_ready),
      .IRWrite(a_irw), .AdrSrc(a_adr), .NextPC(a_npc), .RegW(a_rw), .RegW2(a_rw2),
      .MemW(a_mw), .Branch(a_br), .ALUOp(a_aop), .Half(a_half), .ALUSrcA(a_sa),
      .ALUSrcB(a_sb), .ResultSrc(a_res), .FpuStart(a_fs), .Illegal(a_ill), .State(a_st));

   mainfsm_mc #(.FPU_LAT(3), .EN_FPU16(1'b0)) dut_b (
      .clk(clk), .reset(reset), .Op(op), .Funct(funct), .MemReady(mem_ready),
      .IRWrite(b_irw), .AdrSrc(b_adr), .NextPC(b_npc), .RegW(b_rw), .RegW2(b_rw2),
      .MemW(b_mw), .Branch(b_br), .ALUOp(b_aop), .Half(b_half), .ALUSrcA(b_sa),
      .ALUSrcB(b_sb), .ResultSrc(b_res), .FpuStart(b_fs), .Illegal(b_ill), .State(b_st));

   always #5 clk = ~clk;

   // word layout: state, irw adr npc rw rw2 mw br aluop half, srca srcb res, fs ill
   typedef struct {
      logic [20:0] ea;
      logic [20:0] eb;
      int          id;
   } exp_t;

   exp_t q[$];
   int   n_vec  = 0;
   int   n_miss = 0;
   int   n_cyc  = 0;

   wire [20:0] act_a = {a_st, a_irw, a_adr, a_npc, a_rw, a_rw2, a_mw, a_br, a_aop, a_half,
                        a_sa, a_sb, a_res, a_fs, a_ill};
   wire [20:0] act_b = {b_st, b_irw, b_adr, b_npc, b_rw, b_rw2, b_mw, b_br, b_aop, b_half,
                        b_sa, b_sb, b_res, b_fs, b_ill};

   // Expected control word for a state, from the per-state output table
   function automatic logic [20:0] ew(input logic [3:0] s, input logic mr,
                                      input logic imm, input logic fs);
      logic irw, adr, npc, rw, rw2, mw, br, aop, half, ill;
      logic [1:0] sa, sb, res;
      {irw, adr, npc, rw, rw2, mw, br, aop, half, ill} = '0;
      sa = 2'b00; sb = 2'b00; res = 2'b00;
      case (s)
         4'd0:  begin sa = 2'b01; sb = 2'b10; res = 2'b10; irw = mr; npc = mr; end
         4'd1:  begin sa = 2'b01; sb = 2'b10; res = 2'b10; end
         4'd2:  sb = 2'b01;
         4'd3:  adr = 1'b1;
         4'd4:  begin rw = 1'b1; res = 2'b01; end
         4'd5:  begin adr = 1'b1; mw = 1'b1; end
         4'd6:  aop = 1'b1;
         4'd7:  begin aop = 1'b1; sb = 2'b01; end
         4'd8:  rw = 1'b1;
         4'd9:  begin br = 1'b1; sb = 2'b01; res = 2'b10; end
         4'd10: ill = 1'b1;
         4'd11: begin rw = 1'b1; rw2 = 1'b1; end
         4'd12: begin rw = 1'b1; res = 2'b11; end
         4'd13: begin rw = 1'b1; res = 2'b11; half = 1'b1; end
         4'd14: begin aop = 1'b1; sb = imm ? 2'b01 : 2'b00; end
         default: ;
      endcase
      return {s, irw, adr, npc, rw, rw2, mw, br, aop, half, sa, sb, res,
              fs & (s == 4'd6 || s == 4'd7), ill};
   endfunction

   // One clock of stimulus: drive inputs after the edge, queue expectations
   task automatic cyc(input logic [1:0] o, input logic [5:0] f, input logic mr,
                      input logic [3:0] sa, input logic [3:0] sb,
                      input logic imm, input logic fsa, input logic fsb);
      exp_t e;
      @(posedge clk);
      #1;
      op = o; funct = f; mem_ready = mr;
      e.ea = ew(sa, mr, imm, fsa);
      e.eb = ew(sb, mr, imm, fsb);
      e.id = n_cyc;
      n_cyc++;
      q.push_back(e);
   endtask

   // Same state sequence on both controllers
   task automatic c2(input logic [1:0] o, input logic [5:0] f, input logic mr,
                     input logic [3:0] s, input logic imm, input logic fs);
      cyc(o, f, mr, s, s, imm, fs, fs);
   endtask

   // Monitor: compare whatever the stimulus queued for this cycle
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         n_vec++;
         if (act_a !== e.ea) begin
            n_miss++;
            $display("FAIL cyc%0d dut_a: got %h want %h", e.id, act_a, e.ea);
         end
         n_vec++;
         if (act_b !== e.eb) begin
            n_miss++;
            $display("FAIL cyc%0d dut_b: got %h want %h", e.id, act_b, e.eb);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset held: FETCH outputs, IRWrite/NextPC follow MemReady
      c2(2'b00, 6'b000100, 1'b1, 4'd0, 1'b0, 1'b0);
      c2(2'b00, 6'b000100, 1'b0, 4'd0, 1'b0, 1'b0);
      @(negedge clk); #1 reset = 1'b1;

      // ADD reg: 0,1,6,8
      c2(2'b00, 6'b000100, 1'b0, 4'd0, 1'b0, 1'b0);
      c2(2'b00, 6'b000100, 1'b1, 4'd0, 1'b0, 1'b0);
      c2(2'b00, 6'b000100, 1'b1, 4'd1, 1'b0, 1'b0);
      c2(2'b00, 6'b000100, 1'b1, 4'd6, 1'b0, 1'b0);
      c2(2'b00, 6'b000100, 1'b1, 4'd8, 1'b0, 1'b0);

      // fp32 reg: 0,1,6(start),14x3,12
      c2(2'b00, 6'b011100, 1'b1, 4'd0, 1'b0, 1'b0);
      c2(2'b00, 6'b011100, 1'b1, 4'd1, 1'b0, 1'b0);
      c2(2'b00, 6'b011100, 1'b1, 4'd6, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) c2(2'b00, 6'b011100, 1'b1, 4'd14, 1'b0, 1'b0);
      c2(2'b00, 6'b011100, 1'b1, 4'd12, 1'b0, 1'b0);

      // fp16 imm: A runs 7,14x3,13; B goes 7,10 then idles in FETCH (MemReady=0)
      c2(2'b00, 6'b101100, 1'b1, 4'd0, 1'b0, 1'b0);
      c2(2'b00, 6'b101100, 1'b1, 4'd1, 1'b0, 1'b0);
      cyc(2'b00, 6'b101100, 1'b1, 4'd7, 4'd7, 1'b0, 1'b1, 1'b0);
      cyc(2'b00, 6'b101100, 1'b0, 4'd14, 4'd10, 1'b1, 1'b0, 1'b0);
      cyc(2'b00, 6'b101100, 1'b0, 4'd14, 4'd0, 1'b1, 1'b0, 1'b0);
      cyc(2'b00, 6'b101100, 1'b0, 4'd14, 4'd0, 1'b1, 1'b0, 1'b0);
      cyc(2'b00, 6'b101100, 1'b0, 4'd13, 4'd0, 1'b1, 1'b0, 1'b0);

      // LDR with two MemReady-low cycles in MEMRD
      c2(2'b01, 6'b000001, 1'b1, 4'd0, 1'b0, 1'b0);
      c2(2'b01, 6'b000001, 1'b1, 4'd1, 1'b0, 1'b0);
      c2(2'b01, 6'b000001, 1'b1, 4'd2, 1'b0, 1'b0);
      c2(2'b01, 6'b000001, 1'b0, 4'd3, 1'b0, 1'b0);
      c2(2'b01, 6'b000001, 1'b0, 4'd3, 1'b0, 1'b0);
      c2(2'b01, 6'b000001, 1'b1, 4'd3, 1'b0, 1'b0);
      c2(2'b01, 6'b000001, 1'b1, 4'd4, 1'b0, 1'b0);

      // STR: FETCH stalled once, MEMWRITE stalled twice (MemW 3 cycles)
      c2(2'b01, 6'b000000, 1'b0, 4'd0, 1'b0, 1'b0);
      c2(2'b01, 6'b000000, 1'b1, 4'd0, 1'b0, 1'b0);
      c2(2'b01, 6'b000000, 1'b1, 4'd1, 1'b0, 1'b0);
      c2(2'b01, 6'b000000, 1'b1, 4'd2, 1'b0, 1'b0);
      c2(2'b01, 6'b000000, 1'b0, 4'd5, 1'b0, 1'b0);
      c2(2'b01, 6'b000000, 1'b0, 4'd5, 1'b0, 1'b0);
      c2(2'b01, 6'b000000, 1'b1, 4'd5, 1'b0, 1'b0);

      // long multiply: ALUWB2
      c2(2'b00, 6'b010010, 1'b1, 4'd0, 1'b0, 1'b0);
      c2(2'b00, 6'b010010, 1'b1, 4'd1, 1'b0, 1'b0);
      c2(2'b00, 6'b010010, 1'b1, 4'd6, 1'b0, 1'b0);
      c2(2'b00, 6'b010010, 1'b1, 4'd11, 1'b0, 1'b0);

      // branch
      c2(2'b10, 6'b000000, 1'b1, 4'd0, 1'b0, 1'b0);
      c2(2'b10, 6'b000000, 1'b1, 4'd1, 1'b0, 1'b0);
      c2(2'b10, 6'b000000, 1'b1, 4'd9, 1'b0, 1'b0);

      // Op=11: UNKNOWN
      c2(2'b11, 6'b000000, 1'b1, 4'd0, 1'b0, 1'b0);
      c2(2'b11, 6'b000000, 1'b1, 4'd1, 1'b0, 1'b0);
      c2(2'b11, 6'b000000, 1'b1, 4'd10, 1'b0, 1'b0);

      // ALU immediate
      c2(2'b00, 6'b101000, 1'b1, 4'd0, 1'b0, 1'b0);
      c2(2'b00, 6'b101000, 1'b1, 4'd1, 1'b0, 1'b0);
      c2(2'b00, 6'b101000, 1'b1, 4'd7, 1'b0, 1'b0);
      c2(2'b00, 6'b101000, 1'b1, 4'd8, 1'b0, 1'b0);

      // fp32 imm: ALUSrcB=01 through FPUEXEC
      c2(2'b00, 6'b111110, 1'b1, 4'd0, 1'b0, 1'b0);
      c2(2'b00, 6'b111110, 1'b1, 4'd1, 1'b0, 1'b0);
      c2(2'b00, 6'b111110, 1'b1, 4'd7, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) c2(2'b00, 6'b111110, 1'b1, 4'd14, 1'b1, 1'b0);
      c2(2'b00, 6'b111110, 1'b1, 4'd12, 1'b0, 1'b0);

      // fp32 reg, reset pulsed low during FPUEXEC
      c2(2'b00, 6'b011100, 1'b1, 4'd0, 1'b0, 1'b0);
      c2(2'b00, 6'b011100, 1'b1, 4'd1, 1'b0, 1'b0);
      c2(2'b00, 6'b011100, 1'b1, 4'd6, 1'b0, 1'b1);
      c2(2'b00, 6'b011100, 1'b0, 4'd14, 1'b0, 1'b0);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      n_vec++;
      if (a_st !== 4'd0 || a_rw !== 1'b0 || b_st !== 4'd0 || b_rw !== 1'b0) begin
         n_miss++;
         $display("FAIL async_reset: state a=%0d b=%0d regw a=%b b=%b want 0/0", a_st, b_st, a_rw, b_rw);
      end
      c2(2'b00, 6'b011100, 1'b0, 4'd0, 1'b0, 1'b0);
      @(negedge clk); #1 reset = 1'b1;
      c2(2'b00, 6'b011100, 1'b0, 4'd0, 1'b0, 1'b0);
      c2(2'b00, 6'b011100, 1'b0, 4'd0, 1'b0, 1'b0);
      c2(2'b00, 6'b000100, 1'b1, 4'd0, 1'b0, 1'b0);
      c2(2'b00, 6'b000100, 1'b1, 4'd1, 1'b0, 1'b0);

      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         n_miss++;
         $display("FAIL drain: %0d expectations left want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
